seg_scan_ctrl: RTL

Time-multiplexed scan controller that shares one combinational BCD-to-seven-segment `Decoder` across `NUM_DIGITS` common-anode digits. It holds a frame of BCD digits and steps through them, driving the shared decoder input and the active-low anode lines. It inserts an all-off guard interval between digits to prevent ghosting. New display values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes old and new digits. It sits between the counter/conversion logic (e.g. the units/tens split feeding `Decoder`) and the board's segment/anode pins.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_timer.sv | 42 ++++
 rtl/seg_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared types and helpers for the seven-segment scan controller.
//   scan_state_t : scan FSM phase (GUARD = all dark, ON = one digit lit)
//   SEG_OFF      : active-low segment pattern with every segment dark
//   onehot_low   : active-low anode vector selecting one digit (up to 8)
// ----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    // All ones except the selected digit, which is driven low.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] vec;
        vec      = '1;
        vec[idx] = 1'b0;
        return vec;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// ----------------------------------------------------------------------------
// seg_scan_timer
// Loadable down-counter for the scan phases. tc is high while the count is
// zero; the owner loads (length - 1) on tc, so each phase lasts exactly
// "length" cycles.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value on the next rising edge
//   load_value  : new count (phase length - 1)
//   tc          : terminal count, last cycle of the current phase
// Parameters:
//   WIDTH       : counter width
//   RST_COUNT   : count after reset (length - 1 of the phase entered at reset)
// ----------------------------------------------------------------------------
module seg_scan_timer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RST_COUNT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_COUNT;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one external combinational BCD-to-seven-segment decoder. Each digit
// slot is GUARD_CYCLES all-dark cycles followed by ON_CYCLES lit cycles.
// New frames arrive over a valid/ready handshake into a shadow register and
// are swapped into the active frame only at the frame boundary.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_valid  : producer offers load_value
//   load_ready  : shadow register empty, a frame can be accepted
//   load_value  : BCD digits, digit i in bits [4i+3:4i]
//   blank_mask  : 1 = force digit i dark (sampled every cycle)
//   dec_bcd     : registered BCD to the shared decoder
//   dec_seg     : decoder output (active-low, combinational from dec_bcd)
//   seg_out     : registered active-low segment pins
//   an_out      : registered active-low anode pins, at most one low
//   frame_done  : one-cycle pulse in the last ON cycle of the last digit
// Configuration:
//   SEG_SCAN_LZB_EN : when defined, leading-zero blanking of digits i > 0
// ----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              dec_bcd,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int MAX_CYC = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] ON_LOAD    = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);

    scan_state_t             state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt, shadow;
    logic                    pending;
    logic                    tc, tmr_load;
    logic [TMR_W-1:0]        tmr_load_value;
    logic                    transfer, swap;
    logic [NUM_DIGITS-1:0]   lz_blank, blank;
    logic [NUM_DIGITS-1:0]   an_lit;
    logic                    digit_lit;

    // Reset loads the guard length so the power-up guard is full length.
    seg_scan_timer #(
        .WIDTH     (TMR_W),
        .RST_COUNT (GUARD_LOAD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .tc         (tc)
    );

    // Phase sequencing: every terminal count flips the phase and reloads
    // the timer; leaving ON advances to the next digit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt      = state;
        idx_nxt        = idx;
        tmr_load       = 1'b0;
        tmr_load_value = GUARD_LOAD;
        if (tc) begin
            tmr_load = 1'b1;
            if (state == GUARD) begin
                state_nxt      = ON;
                tmr_load_value = ON_LOAD;
            end else begin
                state_nxt = GUARD;
                idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    assign frame_done = (state == ON) && tc && (idx == LAST_IDX);
    assign load_ready = !pending;
    assign transfer   = load_valid && !pending;
    // transfer needs pending=0 and swap needs pending=1: never both at once.
    assign swap       = frame_done && pending;
    assign active_nxt = swap ? shadow : active;

`ifdef SEG_SCAN_LZB_EN
    // Digit i > 0 goes dark when it and every higher digit are zero.
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run && (active[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign blank     = blank_mask | lz_blank;
    // Outputs are registered from next-state terms so the pins change on the
    // same edge as the phase, and a blank_mask change shows one cycle later.
    assign digit_lit = (state_nxt == ON) && !blank[idx_nxt];
    assign an_lit    = NUM_DIGITS'(onehot_low(3'(idx_nxt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= GUARD;
            idx     <= '0;
            // NOTE: the frame registers are reset too, so a reset mid-frame
            // shows zeros and drops any frame waiting in the shadow.
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            dec_bcd <= 4'd0;
            seg_out <= SEG_OFF;
            an_out  <= '1;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            active <= active_nxt;

            if (transfer) begin
                shadow  <= load_value;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end

            // Held through GUARD so the decoder settles before ON samples it.
            if (state == ON && state_nxt == GUARD) begin
                dec_bcd <= active_nxt[{idx_nxt, 2'b00} +: 4];
            end

            seg_out <= digit_lit ? dec_seg : SEG_OFF;
            an_out  <= digit_lit ? an_lit  : '1;
        end
    end

endmodule
